key_debounce_scheduler: RTL

- Debounces N_KEYS raw push-button inputs with a single shared timer: one 1 ms prescaler and one ms counter, not one per key.
- Round-robin scheduling grants the timer to one key at a time.
- Each grant debounces that key's level change and, if confirmed, updates the stable level and emits a one-cycle press or release pulse.
- Sits between board key pins and downstream LED/control logic; replaces per-key delay/debounce instances.

---
 rtl/key_debounce_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/key_debounce_scheduler.sv
`default_nettype none
// ============================================================================
// key_debounce_scheduler: N-key debouncer sharing one ms timer via round-robin
// Revision: 1.0
// ============================================================================
module key_debounce_scheduler #(
    parameter int          N_KEYS      = 4,
    parameter logic [15:0] T1MS        = 16'd49_999,
    parameter logic [4:0]  DEBOUNCE_MS = 5'd20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_Level,
    output logic [N_KEYS-1:0] Press_Pulse,
    output logic [N_KEYS-1:0] Release_Pulse,
    output logic              Busy,
    output logic [1:0]        Grant_Id
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    localparam logic [1:0] C_RR_RESET = 2'(N_KEYS - 1);

    state_t              state_q, state_d;
    logic [N_KEYS-1:0]   meta_q;
    logic [N_KEYS-1:0]   syn_q;
    logic [N_KEYS-1:0]   syn_prev_q;
    logic [N_KEYS-1:0]   level_q, level_d;
    logic [N_KEYS-1:0]   press_q, press_d;
    logic [N_KEYS-1:0]   release_q, release_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          rr_q, rr_d;
    logic [15:0]         presc_q, presc_d;
    logic [4:0]          ms_q, ms_d;

    logic [N_KEYS-1:0]   req;
    logic                pick_found;
    logic [1:0]          pick_idx;
    logic [1:0]          cand;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q     <= '1;
            syn_q      <= '1;
            syn_prev_q <= '1;
        end else begin
            meta_q     <= Key_In;
            syn_q      <= meta_q;
            syn_prev_q <= syn_q;
        end
    end

    // Level-based requests: a pending change stays visible until serviced.
    assign req = syn_q ^ level_q;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int i = 1; i <= N_KEYS; i++) begin
            cand = 2'((int'(rr_q) + i) % N_KEYS);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            level_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
            grant_q   <= 2'd0;
            rr_q      <= C_RR_RESET;
            presc_q   <= 16'd0;
            ms_q      <= 5'd0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            presc_q   <= presc_d;
            ms_q      <= ms_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        grant_d   = grant_q;
        rr_d      = rr_q;
        presc_d   = presc_q;
        ms_d      = ms_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    presc_d = 16'd0;
                    ms_d    = 5'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Any movement of the granted key restarts the stability window.
                if (syn_q[grant_q] != syn_prev_q[grant_q]) begin
                    presc_d = 16'd0;
                    ms_d    = 5'd0;
                end else if (presc_q == T1MS) begin
                    presc_d = 16'd0;
                    ms_d    = ms_q + 5'd1;
                    if ((ms_q + 5'd1) == DEBOUNCE_MS) begin
                        state_d = S_SAMPLE;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            S_SAMPLE: begin
                if (syn_q[grant_q] != level_q[grant_q]) begin
                    level_d[grant_q] = syn_q[grant_q];
                    if (syn_q[grant_q]) begin
                        release_d[grant_q] = 1'b1;
                    end else begin
                        press_d[grant_q] = 1'b1;
                    end
                end
                rr_d    = grant_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Key_Level     = level_q;
    assign Press_Pulse   = press_q;
    assign Release_Pulse = release_q;
    assign Busy          = (state_q != S_IDLE);
    assign Grant_Id      = grant_q;

endmodule
`default_nettype wire
